// File: rtl/counter_pkg.sv
// counter_pkg
// Shared definitions for the counter arbiter slice: the arbiter state
// encoding, the minimum count accepted by the shared counter, and the
// helper that locates requester k's field inside a packed count bus.
package counter_pkg;

  // Arbiter states; 2-bit encoding covers all four states.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ISSUE   = 2'd1,
    ST_WAIT    = 2'd2,
    ST_RELEASE = 2'd3
  } arb_state_e;

  // Counts below this value are rejected without starting the counter.
  localparam int MIN_CNT = 2;

  // LSB position of slice idx in a packed bus of width-bit fields.
  function automatic int slice_lsb(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/counter_arbiter_rr_pick.sv
// rr_pick
// Combinational round-robin selector. Scans the request vector starting at
// the pointer position and wrapping modulo N_REQ; the first set bit wins.
// Ports:
//   i_req   - request vector
//   i_ptr   - highest-priority position for this scan
//   o_gnt   - one-hot winner (zero when nothing requested)
//   o_idx   - index of the winner (zero when nothing requested)
//   o_valid - at least one request present
module rr_pick
  import counter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int PTR_W = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N_REQ-1:0] o_gnt,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_valid
);

  int               w_cand;
  logic [PTR_W-1:0] w_cand_idx;
  logic             w_hit;

  // Priority scan from i_ptr; once o_valid is set later candidates cannot hit.
  always_comb begin
    o_gnt      = '0;
    o_idx      = '0;
    o_valid    = 1'b0;
    w_cand     = 0;
    w_cand_idx = '0;
    w_hit      = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      // Explicit wrap so non-power-of-2 N_REQ never indexes past N_REQ-1.
      w_cand     = ((int'(i_ptr) + i) >= N_REQ) ? (int'(i_ptr) + i - N_REQ)
                                                : (int'(i_ptr) + i);
      w_cand_idx = w_cand[PTR_W-1:0];
      w_hit      = i_req[w_cand_idx] & ~o_valid;
      o_gnt[w_cand_idx] = o_gnt[w_cand_idx] | w_hit;
      o_idx      = w_hit ? w_cand_idx : o_idx;
      o_valid    = o_valid | w_hit;
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// counter_arbiter
// Round-robin scheduler sharing one counter FSM between N_REQ requesters.
// A granted requester's count is latched, a single start pulse is sent to
// the counter, and when the counter finishes (or the watchdog expires, or
// the count is too small to run) a one-cycle done pulse goes back to the
// owner.
// Ports:
//   clk, rst_n   - clock (rising edge), asynchronous active-low reset
//   req_i        - level requests, held until the matching done_o
//   cnt_val_i    - packed count values, slice k for requester k
//   gnt_o        - one-hot owner, valid ISSUE through RELEASE
//   done_o       - one-cycle completion pulse to the owner
//   err_o        - one-cycle pulse with done_o for rejected/timed-out jobs
//   busy_o       - high whenever not IDLE
//   cnt_start_o  - one-cycle start pulse to the counter
//   cnt_val_o    - latched count value for the counter
//   cnt_done_i   - counter completion, only honoured in WAIT
module counter_arbiter
  import counter_pkg::*;
#(
  parameter int N_REQ     = 4,
  parameter int CNT_WIDTH = 7,
  parameter int TO_CYCLES = 2**CNT_WIDTH + 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req_i,
  input  logic [N_REQ*CNT_WIDTH-1:0] cnt_val_i,
  output logic [N_REQ-1:0]           gnt_o,
  output logic [N_REQ-1:0]           done_o,
  output logic                       err_o,
  output logic                       busy_o,
  output logic                       cnt_start_o,
  output logic [CNT_WIDTH-1:0]       cnt_val_o,
  input  logic                       cnt_done_i
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam int WD_W  = $clog2(TO_CYCLES + 1);
  localparam int LSB_W = $clog2(N_REQ * CNT_WIDTH);

  localparam logic [PTR_W-1:0]     PTR_LAST = PTR_W'(N_REQ - 1);
  localparam logic [WD_W-1:0]      WD_LAST  = WD_W'(TO_CYCLES - 1);
  localparam logic [WD_W-1:0]      WD_MAX   = {WD_W{1'b1}};
  localparam logic [CNT_WIDTH-1:0] CNT_MIN  = CNT_WIDTH'(MIN_CNT);

  arb_state_e           r_state;
  logic [PTR_W-1:0]     r_owner;
  logic [PTR_W-1:0]     r_rr_ptr;
  logic [N_REQ-1:0]     r_gnt;
  logic [N_REQ-1:0]     r_done;
  logic [CNT_WIDTH-1:0] r_cnt_val;
  logic [WD_W-1:0]      r_wd;
  logic                 r_err;
  logic                 r_err_o;
  logic                 r_start;

  logic [N_REQ-1:0]     w_pick_gnt;
  logic [PTR_W-1:0]     w_pick_idx;
  logic                 w_pick_valid;
  logic [LSB_W-1:0]     w_sel_lsb;
  logic [CNT_WIDTH-1:0] w_sel_val;

  rr_pick #(
    .N_REQ (N_REQ),
    .PTR_W (PTR_W)
  ) u_rr_pick (
    .i_req   (req_i),
    .i_ptr   (r_rr_ptr),
    .o_gnt   (w_pick_gnt),
    .o_idx   (w_pick_idx),
    .o_valid (w_pick_valid)
  );

  assign w_sel_lsb = LSB_W'(slice_lsb(int'(w_pick_idx), CNT_WIDTH));
  assign w_sel_val = cnt_val_i[w_sel_lsb +: CNT_WIDTH];

  // Arbiter FSM with latches, watchdog, pointer and registered pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_owner   <= '0;
      r_rr_ptr  <= '0;
      r_gnt     <= '0;
      r_done    <= '0;
      r_cnt_val <= '0;
      r_wd      <= '0;
      r_err     <= 1'b0;
      r_err_o   <= 1'b0;
      r_start   <= 1'b0;
    end else begin
      // Pulse outputs drop back to zero unless re-asserted below.
      r_start <= 1'b0;
      r_done  <= '0;
      r_err_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_pick_valid) begin
            r_state   <= ST_ISSUE;
            r_owner   <= w_pick_idx;
            r_gnt     <= w_pick_gnt;
            r_cnt_val <= w_sel_val;
            // Decide acceptance now so the start pulse lands in ISSUE.
            r_start   <= (w_sel_val >= CNT_MIN);
            r_err     <= (w_sel_val < CNT_MIN);
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          r_wd <= '0;
          if (r_err) begin
            r_state <= ST_RELEASE;
            r_done  <= r_gnt;
            r_err_o <= 1'b1;
          end else begin
            r_state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (cnt_done_i) begin
            r_state <= ST_RELEASE;
            r_done  <= r_gnt;
            r_err_o <= r_err;
          end else if (r_wd == WD_LAST) begin
            r_state <= ST_RELEASE;
            r_err   <= 1'b1;
            r_done  <= r_gnt;
            r_err_o <= 1'b1;
          end else begin
            r_wd <= (r_wd == WD_MAX) ? r_wd : (r_wd + 1'b1);
          end
        end
        ST_RELEASE: begin
          r_state  <= ST_IDLE;
          r_gnt    <= '0;
          r_err    <= 1'b0;
          r_rr_ptr <= (r_owner == PTR_LAST) ? '0 : (r_owner + 1'b1);
        end
        default: begin
          r_state <= ST_IDLE;
          r_gnt   <= '0;
          r_err   <= 1'b0;
        end
      endcase
    end
  end

  assign gnt_o       = r_gnt;
  assign done_o      = r_done;
  assign err_o       = r_err_o;
  assign busy_o      = (r_state != ST_IDLE);
  assign cnt_start_o = r_start;
  assign cnt_val_o   = r_cnt_val;

endmodule

// File: tb/tb_counter_arbiter.sv
// tb_counter_arbiter
// Directed bench for counter_arbiter with a scoreboard of expected jobs.
// Each job's expected owner, count, error flag, start-to-done latency and
// start-pulse count are pushed before the request is raised and popped when
// done_o fires. The bench also plays the counter, raising cnt_done_i a
// chosen number of cycles after each start pulse.
module tb_counter_arbiter;

  localparam int N  = 4;
  localparam int W  = 7;
  localparam int TO = 20;

  logic           clk = 1'b0;
  logic           rst_n;
  logic [N-1:0]   req_i;
  logic [N*W-1:0] cnt_val_i;
  logic [N-1:0]   gnt_o;
  logic [N-1:0]   done_o;
  logic           err_o;
  logic           busy_o;
  logic           cnt_start_o;
  logic [W-1:0]   cnt_val_o;
  logic           cnt_done_i;

  typedef struct {
    logic [N-1:0] gnt;
    logic [W-1:0] val;
    logic         err;
    int           lat;
    int           starts;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  counter_arbiter #(
    .N_REQ     (N),
    .CNT_WIDTH (W),
    .TO_CYCLES (TO)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .cnt_val_i   (cnt_val_i),
    .gnt_o       (gnt_o),
    .done_o      (done_o),
    .err_o       (err_o),
    .busy_o      (busy_o),
    .cnt_start_o (cnt_start_o),
    .cnt_val_o   (cnt_val_o),
    .cnt_done_i  (cnt_done_i)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slice(input int k, input logic [W-1:0] v);
    cnt_val_i[k*W +: W] = v;
  endtask

  task automatic push_job(input logic [N-1:0] g, input logic [W-1:0] v,
                          input logic e, input int lat, input int starts);
    exp_t x;
    x.gnt = g; x.val = v; x.err = e; x.lat = lat; x.starts = starts;
    sb.push_back(x);
  endtask

  // delay: cycles from start pulse to cnt_done_i (-1 = never);
  // drop_at: cycle at which all requests drop (-1 = never);
  // stuck: cnt_done_i stays high once raised; drop_mask: requests cleared on done.
  task automatic run_job(input int delay, input int drop_at, input logic stuck,
                         input logic [N-1:0] drop_mask);
    int   since;
    int   starts;
    int   c;
    bit   got;
    exp_t e;
    since = -1; starts = 0; c = 0; got = 1'b0;
    while (!got && c < 60) begin
      tick();
      if (cnt_start_o === 1'b1) begin
        starts++;
        since = 0;
      end else if (since >= 0) begin
        since++;
      end
      if (c == 0 && sb.size() > 0) check("gnt_at_issue", gnt_o, sb[0].gnt);
      if (c == drop_at) req_i = '0;
      if (done_o !== '0) begin
        got = 1'b1;
        if (sb.size() == 0) begin
          check("sb_nonempty", 64'(sb.size()), 64'd1);
        end else begin
          e = sb.pop_front();
          check("done_owner", done_o, e.gnt);
          check("gnt_in_release", gnt_o, e.gnt);
          check("err_flag", err_o, e.err);
          check("cnt_val", cnt_val_o, e.val);
          check("latency", 64'(c), 64'(e.lat));
          check("start_pulses", 64'(starts), 64'(e.starts));
        end
        req_i = req_i & ~drop_mask;
      end
      cnt_done_i = ((delay >= 0) && (since == delay)) | (stuck & cnt_done_i);
      c++;
    end
    check("job_completed", 64'(got), 64'd1);
    if (got) begin
      tick();
      check("done_one_cycle", done_o, '0);
      check("err_one_cycle", err_o, 1'b0);
      check("idle_after_release", busy_o, 1'b0);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    req_i      = '0;
    cnt_val_i  = '0;
    cnt_done_i = 1'b0;
    tick();
    tick();
    check("rst_gnt", gnt_o, '0);
    check("rst_done", done_o, '0);
    check("rst_busy", busy_o, 1'b0);
    check("rst_start", cnt_start_o, 1'b0);
    check("rst_val", cnt_val_o, '0);
    rst_n = 1'b1;
    tick();

    // Fairness: all four requesting continuously, order 0,1,2,3,0.
    set_slice(0, 7'd5); set_slice(1, 7'd6); set_slice(2, 7'd7); set_slice(3, 7'd8);
    push_job(4'b0001, 7'd5, 1'b0, 4, 1);
    push_job(4'b0010, 7'd6, 1'b0, 2, 1);
    push_job(4'b0100, 7'd7, 1'b0, 6, 1);
    push_job(4'b1000, 7'd8, 1'b0, 3, 1);
    push_job(4'b0001, 7'd5, 1'b0, 5, 1);
    req_i = 4'b1111;
    run_job(3, -1, 1'b0, 4'b0000);
    run_job(1, -1, 1'b0, 4'b0000);
    run_job(5, -1, 1'b0, 4'b0000);
    run_job(2, -1, 1'b0, 4'b0000);
    run_job(4, -1, 1'b0, 4'b1111);

    // Single request, count 10, counter finishes 8 cycles after start.
    set_slice(0, 7'd10);
    push_job(4'b0001, 7'd10, 1'b0, 9, 1);
    req_i = 4'b0001;
    run_job(8, -1, 1'b0, 4'b0001);

    // Rejection: count 1 is below the minimum, done+err two cycles after request.
    set_slice(2, 7'd1);
    push_job(4'b0100, 7'd1, 1'b1, 1, 0);
    req_i = 4'b0100;
    run_job(5, -1, 1'b0, 4'b0100);

    // Timeout: counter never answers, 20 WAIT cycles then RELEASE with err.
    set_slice(3, 7'd9);
    push_job(4'b1000, 7'd9, 1'b1, 21, 1);
    req_i = 4'b1000;
    run_job(-1, -1, 1'b0, 4'b1000);

    // Owner drops its request mid-WAIT; cnt_done_i then sticks high into IDLE.
    set_slice(1, 7'd12);
    push_job(4'b0010, 7'd12, 1'b0, 7, 1);
    req_i = 4'b0010;
    run_job(6, 2, 1'b1, 4'b0010);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stuck_done_busy", busy_o, 1'b0);
      check("stuck_done_start", cnt_start_o, 1'b0);
      check("stuck_done_done", done_o, '0);
    end
    cnt_done_i = 1'b0;

    // Reset in the middle of WAIT aborts the job with no done pulse.
    set_slice(2, 7'd20);
    req_i = 4'b0100;
    tick();
    check("mid_issue_gnt", gnt_o, 4'b0100);
    check("mid_issue_start", cnt_start_o, 1'b1);
    tick();
    tick();
    check("mid_wait_busy", busy_o, 1'b1);
    req_i = '0;
    rst_n = 1'b0;
    #1;
    check("arst_gnt", gnt_o, '0);
    check("arst_start", cnt_start_o, 1'b0);
    check("arst_busy", busy_o, 1'b0);
    check("arst_val", cnt_val_o, '0);
    tick();
    check("arst_no_done", done_o, '0);
    rst_n = 1'b1;
    tick();
    check("post_rst_no_done", done_o, '0);

    // Pointer is back at 0, so 0110 grants requester 1; count 2 is accepted.
    set_slice(1, 7'd2);
    push_job(4'b0010, 7'd2, 1'b0, 3, 1);
    req_i = 4'b0110;
    run_job(2, -1, 1'b0, 4'b0110);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_arbiter.md
# counter_arbiter

Round-robin scheduler that shares one counter FSM unit between N_REQ requesters. It accepts level-held requests, each carrying a terminal count. It grants one requester at a time and issues a single start pulse plus count value to the shared counter. When the counter signals completion, it returns a one-cycle done pulse to the owning requester. It sits between the requesting control blocks and the counter/counter-FSM pair.

## Interface
- N_REQ, 4, number of requesters (2..8)
- CNT_WIDTH, 7, width of count values; must match the shared counter
- TO_CYCLES, 2**CNT_WIDTH + 8, watchdog limit for cycles spent in WAIT
- clk  input  1  clock, rising edge
- rst_n  input  1  reset, asynchronous, active-low
- req_i  input  N_REQ  per-requester request; held high until the matching done_o pulse
- cnt_val_i  input  N_REQ*CNT_WIDTH  packed count values; slice k belongs to requester k
- gnt_o  output  N_REQ  one-hot owner of the counter; all zero when not owned
- done_o  output  N_REQ  one-cycle completion pulse to the owner
- err_o  output  1  one-cycle pulse, coincident with done_o, on rejected or timed-out job
- busy_o  output  1  high in every state except IDLE
- cnt_start_o  output  1  one-cycle start pulse to the counter FSM
- cnt_val_o  output  CNT_WIDTH  latched count value; stable from ISSUE through RELEASE
- cnt_done_i  input  1  done indication from the counter FSM; may be high for 1 or more cycles

## Operation
- States:
  - IDLE: no owner.
  - ISSUE: start pulse driven.
  - WAIT: counter running.
  - RELEASE: done returned to the owner.
- IDLE → ISSUE: when any req_i bit is high.
  - Winner is the first set bit at or after rr_ptr, wrapping modulo N_REQ.
  - Latch the winner's index and its cnt_val_i slice.
- ISSUE → WAIT, with one exception: if the latched value is below MIN_CNT (2), skip the counter and go ISSUE → RELEASE with err flagged.
  - In the rejected case cnt_start_o stays 0.
- WAIT → RELEASE: on cnt_done_i=1, or when the watchdog count reaches TO_CYCLES-1 (err flagged).
- RELEASE → IDLE, unconditional.
  - rr_ptr ← (owner+1) mod N_REQ.
  - err flag cleared.
- req_i deasserting after grant has no effect: the job completes and done_o still pulses.
- req_i changes on non-owners during a job are ignored until the next IDLE.
- cnt_done_i outside WAIT is ignored.
- Watchdog behaviour:
  - Cleared on entry to WAIT.
  - Increments every WAIT cycle.
  - Saturates and does not wrap.
- Width rules:
  - Watchdog width is $clog2(TO_CYCLES+1).
  - Pointer width is $clog2(N_REQ), with an explicit wrap at N_REQ-1 for non-power-of-2 N_REQ.

## Timing
- Reset values: gnt_o=0, done_o=0, err_o=0, busy_o=0, cnt_start_o=0, cnt_val_o=0, rr_ptr=0, state=IDLE.
- Reset is asynchronous and legal in any state. It drops gnt_o and cnt_start_o immediately, and no done_o is emitted for an aborted job.
- All outputs are registered or decoded directly from registered state. No combinational path from req_i to any output.
- Per-job cycle sequence:
  - Cycle t: req seen in IDLE.
  - t+1: ISSUE. cnt_start_o=1 and gnt_o valid; gnt_o stays valid through RELEASE.
  - t+2: WAIT.
  - First cycle with cnt_done_i=1 in WAIT (cycle d): state moves to RELEASE at d+1.
  - d+1: done_o[owner]=1.
  - d+2: IDLE.
  - Earliest next ISSUE: d+3.
- Rejected job: ISSUE at t+1, RELEASE at t+2 with done_o and err_o both high.
- A requester that still holds req_i high one cycle after its done_o is treated as a new request. It ranks lowest, because rr_ptr has moved past it.

## Structure
- Shared package counter_pkg holds:
  - the arbiter state enum (2-bit: IDLE, ISSUE, WAIT, RELEASE);
  - MIN_CNT = 2;
  - the packed-slice index helper, as a function or constant expression.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req vector and pointer.
  - Outputs: one-hot grant, index, and any-valid flag.
- The top holds the FSM, latches, watchdog and pointer.

## Test plan
- Single request: req_i=0001, slice0=10, cnt_done_i 8 cycles after start.
  - Required: one cnt_start_o pulse, cnt_val_o=10, gnt_o=0001, done_o=0001 exactly one cycle, err_o=0.
- Fairness: req_i=1111 held continuously, each job completing.
  - Required: grant order 0,1,2,3,0; no requester granted twice before all others are served.
- Rejection: slice2=1, req_i=0100.
  - Required: no cnt_start_o; done_o=0100 and err_o=1 two cycles after the request.
- Timeout: TO_CYCLES=20, cnt_done_i held low.
  - Required: RELEASE after 20 WAIT cycles, err_o=1, then IDLE.
- Requester drop: owner drops req mid-WAIT.
  - Required: done_o still pulses.
  - Required: a cnt_done_i stuck high into IDLE triggers nothing.
- Reset mid-WAIT.
  - Required: all outputs 0 immediately, rr_ptr=0.
  - Required: the next request is served normally.
